// File: rtl/regfile_write_port_64.sv
// -----------------------------------------------------------------------------
// regfile_write_port_64
//
// Write side of a 32 x W register file. Requests arrive on a valid/ready
// handshake, are decoded to a one-hot load enable in stage 1 and committed
// into the storage registers from stage 2. The stage 2 contents are exposed
// (pend_*) so the read mux can bypass a write that has not landed yet.
// Register ZERO_REG is hardwired to zero: writes to it still flow through the
// pipeline (and are counted) but never change the array.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   wr_valid   write request present
//   wr_ready   request can be accepted this cycle
//   wr_addr    destination register index
//   wr_data    write data
//   hold       stall the commit stage
//   q          flat register contents, register k at q[W*k +: W]
//   pend_valid decoded write waiting in stage 2 (never for ZERO_REG)
//   pend_addr  address of the stage 2 write
//   pend_data  data of the stage 2 write
//   wr_done    one-cycle pulse after a write commits
//   wr_count   committed writes, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module regfile_write_port_64 #(
    parameter int W        = 64,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [4:0]        wr_addr,
    input  logic [W-1:0]      wr_data,
    input  logic              hold,
    output logic [32*W-1:0]   q,
    output logic              pend_valid,
    output logic [4:0]        pend_addr,
    output logic [W-1:0]      pend_data,
    output logic              wr_done,
    output logic [15:0]       wr_count
);

    // Stage 1: accepted and decoded request
    logic              r_s1_valid;
    logic [4:0]        r_s1_addr;
    logic [W-1:0]      r_s1_data;
    logic [31:0]       r_s1_en;

    // Stage 2: request waiting to commit
    logic              r_s2_valid;
    logic [4:0]        r_s2_addr;
    logic [W-1:0]      r_s2_data;
    logic [31:0]       r_s2_en;

    logic              r_wr_done;
    logic [15:0]       r_wr_count;

    logic              w_commit;
    logic              w_s2_free;
    logic              w_handshake;
    logic [31:0]       w_dec_en;

    assign w_commit    = r_s2_valid && !hold;
    // Stage 2 can take a new entry if it is empty or draining this edge.
    assign w_s2_free   = !r_s2_valid || w_commit;
    // Stage 1 can accept when empty or when it is about to move into stage 2,
    // which keeps one write per cycle flowing with hold low.
    assign wr_ready    = !rst && (!r_s1_valid || w_s2_free);
    assign w_handshake = wr_valid && wr_ready;

    // One-hot decode; the zero register never receives a load enable.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_dec
            if (gi == ZERO_REG) begin : g_zero_en
                assign w_dec_en[gi] = 1'b0;
            end else begin : g_reg_en
                assign w_dec_en[gi] = (wr_addr == 5'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_data  <= '0;
            r_s1_en    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_data  <= '0;
            r_s2_en    <= '0;
        end else begin
            if (w_s2_free) begin
                r_s2_valid <= r_s1_valid;
                r_s2_addr  <= r_s1_addr;
                r_s2_data  <= r_s1_data;
                r_s2_en    <= r_s1_en;
            end
            if (w_handshake) begin
                r_s1_valid <= 1'b1;
                r_s1_addr  <= wr_addr;
                r_s1_data  <= wr_data;
                r_s1_en    <= w_dec_en;
            end else if (w_s2_free) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_done  <= 1'b0;
            r_wr_count <= '0;
        end else begin
            r_wr_done <= w_commit;
            if (w_commit && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    // Storage lives in flops rather than block RAM: every register is visible
    // on q at once, which a RAM port cannot provide.
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            if (gi == ZERO_REG) begin : g_zero
                logic w_unused_en;
                assign w_unused_en   = r_s2_en[gi];
                assign q[W*gi +: W]  = '0;
            end else begin : g_store
                logic [W-1:0] r_val;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_val <= '0;
                    end else if (w_commit && r_s2_en[gi]) begin
                        r_val <= r_s2_data;
                    end
                end
                assign q[W*gi +: W] = r_val;
            end
        end
    endgenerate

    assign pend_valid = r_s2_valid && (r_s2_addr != 5'(ZERO_REG));
    assign pend_addr  = r_s2_addr;
    assign pend_data  = r_s2_data;
    assign wr_done    = r_wr_done;
    assign wr_count   = r_wr_count;

endmodule
